// File: rtl/datapath_controller_pkg.sv
// rtl/datapath_controller_pkg.sv - shared types and constants for the datapath control FSM
package datapath_controller_pkg;

  localparam int WIDTH_DEFAULT = 16;

  // Opcode field IR[15:13]
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // Op field IR[12:11]
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  // ALU operation select
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  typedef enum logic [2:0] {
    WAIT      = 3'd0,
    DECODE    = 3'd1,
    LOAD_A    = 3'd2,
    LOAD_B    = 3'd3,
    COMPUTE   = 3'd4,
    WRITE_REG = 3'd5,
    WRITE_IMM = 3'd6,
    ILLEGAL   = 3'd7
  } state_t;

  // ALU-class op field to ALU operation; the encodings line up, but the
  // mapping is kept explicit so either side can be renumbered independently.
  function automatic logic [1:0] alu_for_op(input logic [1:0] op);
    logic [1:0] r;
    case (op)
      OP_ADD:  r = ALU_ADD;
      OP_CMP:  r = ALU_SUB;
      OP_AND:  r = ALU_AND;
      default: r = ALU_NOTB;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/datapath_controller_instr_decoder.sv
// rtl/datapath_controller_instr_decoder.sv - combinational field split and class decode of the IR
module datapath_controller_instr_decoder
  import datapath_controller_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [15:0]      ir,
  output logic [2:0]       rn,
  output logic [2:0]       rd,
  output logic [2:0]       rm,
  output logic [1:0]       sh,
  output logic [1:0]       op,
  output logic [WIDTH-1:0] sximm8,
  output logic             is_mov_imm,
  output logic             is_mov_reg,
  output logic             is_alu,
  output logic             is_cmp,
  output logic             is_mvn,
  output logic             illegal
);

  logic [2:0] opcode;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm8 = {{(WIDTH-8){ir[7]}}, ir[7:0]};

  // Classify the instruction; anything outside the two opcode groups is illegal.
  always_comb begin
    is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
    is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
    is_alu     = (opcode == OPC_ALU);
    is_cmp     = is_alu && (op == OP_CMP);
    is_mvn     = is_alu && (op == OP_MVN);
    illegal    = !(is_mov_imm || is_mov_reg || is_alu);
  end

endmodule

// File: rtl/datapath_controller.sv
// rtl/datapath_controller.sv - instruction handshake, IR and strobe sequencing FSM
module datapath_controller
  import datapath_controller_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s,
  input  logic [15:0]      in,
  output logic             w,
  output logic             err,
  output logic [2:0]       readnum,
  output logic [2:0]       writenum,
  output logic             write,
  output logic             vsel,
  output logic             loada,
  output logic             loadb,
  output logic             asel,
  output logic             bsel,
  output logic             loadc,
  output logic             loads,
  output logic [1:0]       shift,
  output logic [1:0]       ALUop,
  output logic [WIDTH-1:0] datapath_in
);

  state_t      state_q, state_d;
  logic [15:0] ir_q;

  logic [2:0]       rn, rd, rm;
  logic [1:0]       sh, op;
  logic [WIDTH-1:0] sximm8;
  logic             is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn, illegal;

  datapath_controller_instr_decoder #(.WIDTH(WIDTH)) u_dec (
    .ir         (ir_q),
    .rn         (rn),
    .rd         (rd),
    .rm         (rm),
    .sh         (sh),
    .op         (op),
    .sximm8     (sximm8),
    .is_mov_imm (is_mov_imm),
    .is_mov_reg (is_mov_reg),
    .is_alu     (is_alu),
    .is_cmp     (is_cmp),
    .is_mvn     (is_mvn),
    .illegal    (illegal)
  );

  assign datapath_in = sximm8;
  assign bsel        = 1'b0;

  // State and IR registers; the IR only captures on an accepted start.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == WAIT && s) begin
        ir_q <= in;
      end
    end
  end

  // Next-state: one datapath step per cycle, then back to WAIT.
  always_comb begin
    state_d = WAIT;
    case (state_q)
      WAIT:      state_d = s ? DECODE : WAIT;
      DECODE: begin
        if (illegal)                     state_d = ILLEGAL;
        else if (is_mov_imm)             state_d = WRITE_IMM;
        else if (is_mov_reg || is_mvn)   state_d = LOAD_B;
        else if (is_alu)                 state_d = LOAD_A;
        else                             state_d = ILLEGAL;
      end
      LOAD_A:    state_d = LOAD_B;
      LOAD_B:    state_d = COMPUTE;
      COMPUTE:   state_d = is_cmp ? WAIT : WRITE_REG;
      WRITE_REG: state_d = WAIT;
      WRITE_IMM: state_d = WAIT;
      ILLEGAL:   state_d = WAIT;
      default:   state_d = WAIT;
    endcase
  end

  // Moore strobes decoded from state and IR fields; all idle by default.
  always_comb begin
    w        = 1'b0;
    err      = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    vsel     = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    asel     = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    shift    = 2'b00;
    ALUop    = ALU_ADD;
    case (state_q)
      WAIT:   w = 1'b1;
      LOAD_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      LOAD_B: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      COMPUTE: begin
        shift = sh;
        // MOV-reg passes B through as 0 + B; MVN ignores A entirely.
        asel  = is_mov_reg || is_mvn;
        ALUop = is_mov_reg ? ALU_ADD : alu_for_op(op);
        loads = is_cmp;
        loadc = !is_cmp;
      end
      WRITE_REG: begin
        writenum = rd;
        vsel     = 1'b0;
        write    = 1'b1;
      end
      WRITE_IMM: begin
        writenum = rn;
        vsel     = 1'b1;
        write    = 1'b1;
      end
      ILLEGAL: err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_datapath_controller.sv
// tb/tb_datapath_controller.sv - directed table-driven bench for datapath_controller
module tb_datapath_controller;

  logic        clk;
  logic        reset_n;
  logic        s;
  logic [15:0] in;
  logic        w, err, write, vsel, loada, loadb, asel, bsel, loadc, loads;
  logic [2:0]  readnum, writenum;
  logic [1:0]  shift, ALUop;
  logic [15:0] datapath_in;

  datapath_controller #(.WIDTH(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s           (s),
    .in          (in),
    .w           (w),
    .err         (err),
    .readnum     (readnum),
    .writenum    (writenum),
    .write       (write),
    .vsel        (vsel),
    .loada       (loada),
    .loadb       (loadb),
    .asel        (asel),
    .bsel        (bsel),
    .loadc       (loadc),
    .loads       (loads),
    .shift       (shift),
    .ALUop       (ALUop),
    .datapath_in (datapath_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] instr;
    int          lat;
    int          a_at;
    logic [2:0]  a_rn;
    int          b_at;
    logic [2:0]  b_rn;
    int          c_at;
    logic        c_is_s;
    logic [1:0]  c_alu;
    logic [1:0]  c_sh;
    logic        c_asel;
    int          wr_at;
    logic [2:0]  wr_num;
    logic        wr_vsel;
    logic [15:0] wr_dpin;
    int          err_at;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs [NVEC];

  int n_cmp = 0;
  int n_bad = 0;

  // observations from the most recent instruction
  int          o_lat, o_a_at, o_b_at, o_c_at, o_wr_at, o_err_at;
  int          o_a_cnt, o_b_cnt, o_c_cnt, o_wr_cnt, o_err_cnt, o_bsel_cnt, o_both_cnt;
  logic [2:0]  o_a_rn, o_b_rn, o_wr_num;
  logic        o_c_is_s, o_c_asel, o_wr_vsel;
  logic [1:0]  o_c_alu, o_c_sh;
  logic [15:0] o_wr_dpin;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    s       = 1'b0;
    in      = 16'h0000;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Accept one instruction and record every strobe until w returns (or budget runs out).
  task automatic run_instr(input logic [15:0] instr, input logic poke_busy);
    o_lat = 0; o_a_at = 0; o_b_at = 0; o_c_at = 0; o_wr_at = 0; o_err_at = 0;
    o_a_cnt = 0; o_b_cnt = 0; o_c_cnt = 0; o_wr_cnt = 0; o_err_cnt = 0;
    o_bsel_cnt = 0; o_both_cnt = 0;
    o_a_rn = 0; o_b_rn = 0; o_wr_num = 0; o_c_is_s = 0; o_c_asel = 0;
    o_wr_vsel = 0; o_c_alu = 0; o_c_sh = 0; o_wr_dpin = 0;
    @(negedge clk);
    in = instr;
    s  = 1'b1;
    for (int k = 1; k <= 20 && o_lat == 0; k++) begin
      @(negedge clk);
      s = 1'b0;
      if (poke_busy && k == 2) begin
        s  = 1'b1;
        in = 16'hD107;
      end
      if (loada) begin
        o_a_cnt++;
        if (o_a_at == 0) begin o_a_at = k; o_a_rn = readnum; end
      end
      if (loadb) begin
        o_b_cnt++;
        if (o_b_at == 0) begin o_b_at = k; o_b_rn = readnum; end
      end
      if (loadc && loads) o_both_cnt++;
      if (loadc || loads) begin
        o_c_cnt++;
        if (o_c_at == 0) begin
          o_c_at = k; o_c_is_s = loads; o_c_alu = ALUop; o_c_sh = shift; o_c_asel = asel;
        end
      end
      if (write) begin
        o_wr_cnt++;
        if (o_wr_at == 0) begin
          o_wr_at = k; o_wr_num = writenum; o_wr_vsel = vsel; o_wr_dpin = datapath_in;
        end
      end
      if (err) begin
        o_err_cnt++;
        if (o_err_at == 0) o_err_at = k;
      end
      if (bsel) o_bsel_cnt++;
      if (w) o_lat = k;
    end
    s = 1'b0;
  endtask

  task automatic check_vec(input vec_t v);
    chk({v.name, ".latency"},  o_lat,      v.lat);
    chk({v.name, ".loada_at"}, o_a_at,     v.a_at);
    chk({v.name, ".loadb_at"}, o_b_at,     v.b_at);
    chk({v.name, ".comp_at"},  o_c_at,     v.c_at);
    chk({v.name, ".write_at"}, o_wr_at,    v.wr_at);
    chk({v.name, ".err_at"},   o_err_at,   v.err_at);
    chk({v.name, ".loada_n"},  o_a_cnt,    (v.a_at != 0) ? 1 : 0);
    chk({v.name, ".loadb_n"},  o_b_cnt,    (v.b_at != 0) ? 1 : 0);
    chk({v.name, ".comp_n"},   o_c_cnt,    (v.c_at != 0) ? 1 : 0);
    chk({v.name, ".write_n"},  o_wr_cnt,   (v.wr_at != 0) ? 1 : 0);
    chk({v.name, ".err_n"},    o_err_cnt,  (v.err_at != 0) ? 1 : 0);
    chk({v.name, ".bsel_n"},   o_bsel_cnt, 0);
    chk({v.name, ".c_and_s"},  o_both_cnt, 0);
    if (v.a_at != 0) chk({v.name, ".a_readnum"}, o_a_rn, v.a_rn);
    if (v.b_at != 0) chk({v.name, ".b_readnum"}, o_b_rn, v.b_rn);
    if (v.c_at != 0) begin
      chk({v.name, ".loads"}, o_c_is_s, v.c_is_s);
      chk({v.name, ".ALUop"}, o_c_alu,  v.c_alu);
      chk({v.name, ".shift"}, o_c_sh,   v.c_sh);
      chk({v.name, ".asel"},  o_c_asel, v.c_asel);
    end
    if (v.wr_at != 0) begin
      chk({v.name, ".writenum"},    o_wr_num,  v.wr_num);
      chk({v.name, ".vsel"},        o_wr_vsel, v.wr_vsel);
      chk({v.name, ".datapath_in"}, o_wr_dpin, v.wr_dpin);
    end
  endtask

  initial begin
    logic [5:0] exp_w_b2b;
    logic [5:0] exp_wr_b2b;
    int         bad_cycles;

    //          name         instr     lat a rn   b rn   c  s     alu    sh     asel  wr num   vsel  dpin       err
    vecs[0] = '{"mov_imm7",  16'hD107, 3, 0,3'd0, 0,3'd0, 0,1'b0,2'b00,2'b00,1'b0, 2,3'd1,1'b1,16'h0007, 0};
    vecs[1] = '{"mov_imm_n", 16'hD1F0, 3, 0,3'd0, 0,3'd0, 0,1'b0,2'b00,2'b00,1'b0, 2,3'd1,1'b1,16'hFFF0, 0};
    vecs[2] = '{"add",       16'hA140, 6, 2,3'd1, 3,3'd0, 4,1'b0,2'b00,2'b00,1'b0, 5,3'd2,1'b0,16'h0040, 0};
    vecs[3] = '{"cmp",       16'hA908, 5, 2,3'd1, 3,3'd0, 4,1'b1,2'b01,2'b01,1'b0, 0,3'd0,1'b0,16'h0000, 0};
    vecs[4] = '{"ill_e000",  16'hE000, 3, 0,3'd0, 0,3'd0, 0,1'b0,2'b00,2'b00,1'b0, 0,3'd0,1'b0,16'h0000, 2};
    vecs[5] = '{"mov_reg",   16'hC075, 5, 0,3'd0, 2,3'd5, 3,1'b0,2'b00,2'b10,1'b1, 4,3'd3,1'b0,16'h0075, 0};
    vecs[6] = '{"mvn",       16'hB886, 5, 0,3'd0, 2,3'd6, 3,1'b0,2'b11,2'b00,1'b1, 4,3'd4,1'b0,16'hFF86, 0};
    vecs[7] = '{"and",       16'hB2FB, 6, 2,3'd2, 3,3'd3, 4,1'b0,2'b10,2'b11,1'b0, 5,3'd7,1'b0,16'hFFFB, 0};
    vecs[8] = '{"ill_c800",  16'hC800, 3, 0,3'd0, 0,3'd0, 0,1'b0,2'b00,2'b00,1'b0, 0,3'd0,1'b0,16'h0000, 2};

    reset_n = 1'b0;
    s       = 1'b0;
    in      = 16'h0000;
    do_reset();

    // idle state straight after reset
    @(negedge clk);
    chk("rst.w",           w,           1'b1);
    chk("rst.err",         err,         1'b0);
    chk("rst.write",       write,       1'b0);
    chk("rst.loads_any",   {loada, loadb, loadc, loads}, 4'b0000);
    chk("rst.datapath_in", datapath_in, 16'h0000);

    for (int i = 0; i < NVEC; i++) begin
      run_instr(vecs[i].instr, 1'b0);
      check_vec(vecs[i]);
    end

    // s pulsed while busy must not start a second instruction or disturb the IR
    run_instr(16'hA140, 1'b1);
    check_vec(vecs[2]);
    bad_cycles = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (!w || write || loada || loadb) bad_cycles++;
    end
    chk("busy_s.idle_after", bad_cycles, 0);
    chk("busy_s.ir_kept", datapath_in, 16'h0040);

    // s held high: a new instruction is taken on every WAIT cycle
    @(negedge clk);
    in = 16'hD107;
    s  = 1'b1;
    exp_w_b2b  = 6'b100100;
    exp_wr_b2b = 6'b010010;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("b2b.w[%0d]", k),     w,     exp_w_b2b[k-1]);
      chk($sformatf("b2b.write[%0d]", k), write, exp_wr_b2b[k-1]);
    end
    s = 1'b0;
    repeat (3) @(negedge clk);

    // reset during LOAD_B of an ADD aborts it
    in = 16'hA140;
    s  = 1'b1;
    @(negedge clk);
    s = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort.in_load_b", loadb, 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort.w",           w,           1'b1);
    chk("abort.strobes",     {write, loada, loadb, loadc, loads}, 5'b00000);
    chk("abort.datapath_in", datapath_in, 16'h0000);
    reset_n = 1'b1;
    bad_cycles = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (!w || write) bad_cycles++;
    end
    chk("abort.no_write", bad_cycles, 0);

    // reset dominates a simultaneous start
    in      = 16'hD107;
    s       = 1'b1;
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_vs_s.w",           w,           1'b1);
    chk("rst_vs_s.datapath_in", datapath_in, 16'h0000);
    s       = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_vs_s.still_idle", w, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/datapath_controller.md
Name: datapath_controller

Overview:
- Control FSM that drives the existing 16-bit datapath, which consumes readnum/writenum/write/vsel/loada/loadb/asel/bsel/loadc/loads/shift/ALUop/datapath_in and returns status.
- Accepts one instruction via an s/w handshake, decodes it and sequences the datapath strobes one step per cycle.
- Returns to WAIT when the instruction completes.
- Sits between the instruction source (memory/testbench) and the datapath.

Parameters:
WIDTH, 16, datapath word width; datapath_in is sign-extended to WIDTH.

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  synchronous active-low reset
s  in  1  start; sampled only in WAIT
in  in  16  instruction word; latched with s
w  out  1  1 = idle in WAIT, ready for s
err  out  1  one-cycle pulse on illegal instruction
readnum  out  3  register-file read index
writenum  out  3  register-file write index
write  out  1  register-file write enable
vsel  out  1  1 = write datapath_in, 0 = write C
loada  out  1  load A from read port
loadb  out  1  load B from read port
asel  out  1  1 = ALU A input forced to 0
bsel  out  1  tied 0 in this ISA revision
loadc  out  1  load C from ALU
loads  out  1  load status (Z) from ALU
shift  out  2  shifter op for B
ALUop  out  2  00 add, 01 sub, 10 and, 11 not-B
datapath_in  out  WIDTH  sign-extended imm8 from IR

Behaviour:
- Instruction fields:
  - opcode = IR[15:13], op = IR[12:11], Rn = IR[10:8], Rd = IR[7:5], sh = IR[4:3], Rm = IR[2:0], imm8 = IR[7:0].
- Legal instructions:
  - MOV Rn,#imm8: opcode 110, op 10
  - MOV Rd,Rm{,sh}: opcode 110, op 00
  - ADD: opcode 101, op 00
  - CMP: opcode 101, op 01
  - AND: opcode 101, op 10
  - MVN: opcode 101, op 11
  - Everything else is illegal.
- IR register: loaded only when state == WAIT and s == 1. Holds its value otherwise. Resets to 0.
- datapath_in = {{8{IR[7]}}, IR[7:0]}, combinational from IR. Value after reset: 0.
- All control outputs are Moore functions of state (plus IR fields). Any strobe not listed for a state is 0.
- States and outputs:
  - WAIT: w=1.
  - DECODE: all strobes 0.
  - LOAD_A: readnum=Rn, loada=1.
  - LOAD_B: readnum=Rm, loadb=1.
  - COMPUTE: shift=sh, ALUop=op, asel=1 for MOV-reg (ALUop forced 00) and MVN. CMP sets loads=1, loadc=0; all other instructions set loadc=1, loads=0.
  - WRITE_REG: writenum=Rd, vsel=0, write=1.
  - WRITE_IMM: writenum=Rn, vsel=1, write=1.
  - ILLEGAL: err=1.
- Transitions:
  - WAIT -> DECODE on s, else stay in WAIT.
  - DECODE -> WRITE_IMM for MOV-imm.
  - DECODE -> LOAD_B for MOV-reg and MVN.
  - DECODE -> LOAD_A for ADD, CMP and AND.
  - DECODE -> ILLEGAL for anything else.
  - LOAD_A -> LOAD_B -> COMPUTE.
  - COMPUTE -> WAIT for CMP, else -> WRITE_REG.
  - WRITE_REG, WRITE_IMM and ILLEGAL -> WAIT.
- Latency, in cycles from the s-accept edge to w=1:
  - MOV-imm: 3
  - MOV-reg and MVN: 5
  - ADD and AND: 6
  - CMP: 5
  - illegal: 3
- s outside WAIT is ignored, and in changes outside WAIT have no effect.
- s held high continuously: a new instruction is accepted on every WAIT cycle (back-to-back).
- Reset:
  - reset_n=0 at any edge forces state to WAIT and IR to 0, overriding s.
  - Reset mid-instruction aborts the instruction. No write or load strobe is asserted in the cycle after the reset edge.
  - Reset dominates simultaneous s.
- state_q has no unreachable encodings that lock up: any undefined encoding transitions to WAIT.

Decomposition:
- Shared package holds:
  - the state enum (WAIT, DECODE, LOAD_A, LOAD_B, COMPUTE, WRITE_REG, WRITE_IMM, ILLEGAL)
  - opcode constants (OPC_MOV=3'b110, OPC_ALU=3'b101)
  - op constants
  - ALUop encodings
  - the WIDTH default
- One natural sub-module: instr_decoder. It is combinational and maps IR to {Rn, Rd, Rm, sh, op, sximm8, is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn, illegal}.
- The FSM and the output logic stay in datapath_controller.

Test Plan:
- Reset then in=16'hD107, s=1 for 1 cycle (MOV R1,#7):
  - WRITE_IMM cycle shows write=1, writenum=1, vsel=1, datapath_in=16'h0007.
  - w=1 three cycles after accept.
- in=16'hD1F0 (MOV R1,#-16) -> datapath_in=16'hFFF0 in WRITE_IMM.
- in=16'hA140 (ADD R2,R1,R0), expected strobe order:
  - loada with readnum=1
  - loadb with readnum=0
  - loadc with ALUop=00, shift=00
  - write with writenum=2, vsel=0
  - w=1 six cycles after accept.
- in=16'hA908 (CMP R1,R0,LSL#1) -> COMPUTE has loads=1, loadc=0, ALUop=01, shift=01. No write asserted. Back in WAIT after 5 cycles.
- in=16'hE000 -> err=1 for exactly one cycle, no load/write strobes asserted, w=1 after 3 cycles.
- Start ADD, drive reset_n=0 during LOAD_B -> next cycle w=1, write never asserted, IR=0, datapath_in=0. s pulsed during a busy cycle is ignored, with no extra instruction executed.
